// File: rtl/sprite_anim_display.sv
// sprite_anim_display: pipelined sprite renderer with colour-key transparency, mirroring and frame-tick animation
module sprite_anim_display #(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter int NUM_FRAMES = 4,
    parameter int TICKS_PER_FRAME = 8,
    parameter int ADDR_W = 12,
    parameter int COLOR_W = 12,
    parameter logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F,
    localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [10:0]        x,
    input  logic [9:0]         y,
    input  logic [10:0]        sprite_x,
    input  logic [9:0]         sprite_y,
    input  logic               frame_tick,
    input  logic               anim_en,
    input  logic               anim_oneshot,
    input  logic               restart,
    input  logic               flip_h,
    input  logic               flip_v,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] rgb_out,
    output logic               pixel_on,
    output logic [FW-1:0]      frame_idx,
    output logic               anim_done
);
    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam int TW = TICKS_PER_FRAME > 1 ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [FW-1:0] LAST = FW'(NUM_FRAMES - 1);
    localparam logic [TW-1:0] TLAST = TW'(TICKS_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t state, state_nx;
    logic [TW-1:0] tick, tick_nx;
    logic [FW-1:0] frame_nx;
    logic done_nx, play_tick, adv, last, stop;
    logic [11:0] dx;
    logic [10:0] dy;
    logic hit, hit_d1, hit_d2;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [FW+RW+CW-1:0] addr_full;

    // A borrow makes the 12/11-bit difference huge, so one unsigned compare rejects it
    assign dx = {1'b0, x} - {1'b0, sprite_x};
    assign dy = {1'b0, y} - {1'b0, sprite_y};
    assign hit = dx < 12'(SPR_W) && dy < 11'(SPR_H);
    assign col = flip_h ? ~dx[CW-1:0] : dx[CW-1:0];
    assign row = flip_v ? ~dy[RW-1:0] : dy[RW-1:0];
    assign addr_full = {frame_idx, row, col};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            hit_d1 <= 1'b0;
            hit_d2 <= 1'b0;
        end else begin
            rom_addr <= ADDR_W'(addr_full);
            hit_d1 <= hit;
            hit_d2 <= hit_d1;
        end
    end

    assign pixel_on = hit_d2 && rom_data != KEY_COLOR;
    assign rgb_out = pixel_on ? rom_data : '0;

    assign play_tick = state == PLAY && anim_en && frame_tick;
    assign adv = play_tick && tick == TLAST;
    assign last = frame_idx == LAST;
    assign stop = adv && last && anim_oneshot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            frame_idx <= '0;
            tick <= '0;
            anim_done <= 1'b0;
        end else begin
            state <= state_nx;
            frame_idx <= frame_nx;
            tick <= tick_nx;
            anim_done <= done_nx;
        end
    end

    always_comb begin
        state_nx = (restart || state == IDLE) ? (anim_en ? PLAY : IDLE) :
                   state == PLAY ? (!anim_en ? IDLE : stop ? DONE : PLAY) : DONE;
    end

    always_comb begin
        tick_nx = restart ? '0 : play_tick ? (tick == TLAST ? '0 : tick + TW'(1)) : tick;
        frame_nx = restart ? '0 : (adv && !last) ? frame_idx + FW'(1) :
                   (adv && !anim_oneshot) ? '0 : frame_idx;
        done_nx = !restart && (anim_done || stop);
    end
endmodule

// File: tb/tb_sprite_anim_display.sv
// tb_sprite_anim_display: scoreboard bench with a behavioural ROM and animation model
module tb_sprite_anim_display;
    localparam int SW = 32, SH = 32, NF = 4, TPF = 8, AW = 12;
    localparam logic [11:0] KEY = 12'hF0F;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [10:0] x = '0, sprite_x = '0;
    logic [9:0] y = '0, sprite_y = '0;
    logic frame_tick = 1'b0, anim_en = 1'b0, anim_oneshot = 1'b0, restart = 1'b0;
    logic flip_h = 1'b0, flip_v = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [11:0] rom_data = '0, rgb_out;
    logic pixel_on, anim_done;
    logic [1:0] frame_idx;
    logic [11:0] rom [1<<AW];

    typedef struct {int cyc; bit chk_addr; int addr; int frame; bit done;} e1_t;
    typedef struct {int cyc; int rgb; bit pon;} e2_t;
    e1_t q1[$];
    e2_t q2[$];

    int cyc = 0, checks = 0, errors = 0;
    int m_ticks = 0;
    bit m_prev_en = 0, m_os = 0;

    sprite_anim_display dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .frame_tick(frame_tick), .anim_en(anim_en), .anim_oneshot(anim_oneshot),
        .restart(restart), .flip_h(flip_h), .flip_v(flip_v), .rom_addr(rom_addr),
        .rom_data(rom_data), .rgb_out(rgb_out), .pixel_on(pixel_on),
        .frame_idx(frame_idx), .anim_done(anim_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, act, exp);
        end
    endfunction

    // Animation state expressed as ticks accepted since the last restart
    function automatic int m_frame();
        int n = m_ticks / TPF;
        return m_os ? (n >= NF ? NF - 1 : n) : n % NF;
    endfunction

    function automatic bit m_done();
        return m_os && m_ticks >= TPF * NF;
    endfunction

    task automatic cyc_step(input int xi, input int yi, input bit ft, input bit rs);
        int dx, dy, col, row, a;
        bit hit;
        e1_t e1;
        e2_t e2;
        @(negedge clk);
        x = 11'(xi);
        y = 10'(yi);
        frame_tick = ft;
        restart = rs;
        dx = xi - int'(sprite_x);
        dy = yi - int'(sprite_y);
        hit = dx >= 0 && dx < SW && dy >= 0 && dy < SH;
        col = flip_h ? SW - 1 - dx : dx;
        row = flip_v ? SH - 1 - dy : dy;
        a = hit ? (m_frame() * SW * SH + row * SW + col) % (1 << AW) : 0;
        e2.cyc = cyc;
        e2.pon = hit && rom[a] != KEY;
        e2.rgb = e2.pon ? int'(rom[a]) : 0;
        if (rs) begin
            m_ticks = 0;
            m_os = anim_oneshot;
        end else if (ft && anim_en && m_prev_en && !m_done()) m_ticks++;
        m_prev_en = anim_en;
        e1.cyc = cyc;
        e1.chk_addr = hit;
        e1.addr = a;
        e1.frame = m_frame();
        e1.done = m_done();
        q1.push_back(e1);
        q2.push_back(e2);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (q1.size() > 0 && q1[0].cyc + 1 <= cyc) begin
                e1_t e;
                e = q1.pop_front();
                if (e.chk_addr) chk("rom_addr", int'(rom_addr), e.addr);
                chk("frame_idx", int'(frame_idx), e.frame);
                chk("anim_done", int'(anim_done), int'(e.done));
            end
            if (q2.size() > 0 && q2[0].cyc + 2 <= cyc) begin
                e2_t e;
                e = q2.pop_front();
                chk("rgb_out", int'(rgb_out), e.rgb);
                chk("pixel_on", int'(pixel_on), int'(e.pon));
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
        rom[65] = KEY;
        rom[66] = 12'h0A3;
        #12;
        chk("reset_rgb", int'(rgb_out), 0);
        chk("reset_pon", int'(pixel_on), 0);
        chk("reset_frame", int'(frame_idx), 0);
        chk("reset_done", int'(anim_done), 0);
        chk("reset_addr", int'(rom_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // Hit bounds, including a sprite hanging off the right edge
        sprite_x = 11'd100;
        sprite_y = 10'd50;
        for (int i = 99; i <= 132; i++) cyc_step(i, 50, 0, 0);
        sprite_x = 11'd2040;
        for (int i = 0; i <= 5; i++) cyc_step(i, 50, 0, 0);
        for (int i = 2038; i <= 2047; i++) cyc_step(i, 60, 0, 0);
        // Addressing and mirroring
        sprite_x = 11'd100;
        cyc_step(101, 52, 0, 0);
        chk("addr_plain", int'(rom_addr), 65);
        flip_h = 1'b1;
        cyc_step(101, 52, 0, 0);
        chk("addr_flip_h", int'(rom_addr), 94);
        flip_h = 1'b0;
        flip_v = 1'b1;
        cyc_step(101, 52, 0, 0);
        chk("addr_flip_v", int'(rom_addr), 929);
        flip_v = 1'b0;
        // Colour key transparency
        cyc_step(101, 52, 0, 0);
        cyc_step(102, 52, 0, 0);
        chk("key_rgb", int'(rgb_out), 0);
        chk("key_pon", int'(pixel_on), 0);
        cyc_step(0, 0, 0, 0);
        chk("opaque_rgb", int'(rgb_out), 'h0A3);
        chk("opaque_pon", int'(pixel_on), 1);
        // Looping animation
        anim_en = 1'b1;
        anim_oneshot = 1'b0;
        cyc_step(0, 0, 0, 1);
        for (int t = 1; t <= 32; t++) begin
            cyc_step(100 + int'($urandom_range(0, 31)), 50 + int'($urandom_range(0, 31)), 1, 0);
            if (t % 8 == 0) chk("loop_frame", int'(frame_idx), (t / 8) % 4);
            if (t == 20) begin
                cyc_step(100, 50, 0, 0);
                chk("loop_addr_f2", int'(rom_addr), 2048);
            end
        end
        // One-shot then restart coincident with a tick
        anim_oneshot = 1'b1;
        cyc_step(0, 0, 0, 1);
        for (int t = 0; t < 40; t++) cyc_step(100 + t % 32, 60, 1, 0);
        chk("oneshot_frame", int'(frame_idx), 3);
        chk("oneshot_done", int'(anim_done), 1);
        cyc_step(100, 50, 1, 1);
        chk("restart_frame", int'(frame_idx), 0);
        chk("restart_done", int'(anim_done), 0);
        for (int t = 0; t < 8; t++) cyc_step(110, 55, 1, 0);
        chk("restart_play", int'(frame_idx), 1);
        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit rs;
            if ($urandom_range(0, 39) == 0) anim_en = ~anim_en;
            if ($urandom_range(0, 15) == 0) begin
                sprite_x = 11'($urandom);
                sprite_y = 10'($urandom);
            end
            flip_h = 1'($urandom);
            flip_v = 1'($urandom);
            rs = $urandom_range(0, 199) == 0;
            if (rs) anim_oneshot = 1'($urandom);
            cyc_step((int'(sprite_x) + int'($urandom_range(0, 40)) - 4) & 2047,
                     (int'(sprite_y) + int'($urandom_range(0, 40)) - 4) & 1023,
                     $urandom_range(0, 2) == 0, rs);
        end
        // Asynchronous reset while drawing a non-zero frame
        anim_en = 1'b1;
        anim_oneshot = 1'b0;
        flip_h = 1'b0;
        flip_v = 1'b0;
        sprite_x = 11'd200;
        sprite_y = 10'd100;
        cyc_step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc_step(200 + i, 100 + i, 1, 0);
        cyc_step(205, 105, 0, 0);
        cyc_step(206, 105, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rgb", int'(rgb_out), 0);
        chk("async_pon", int'(pixel_on), 0);
        chk("async_frame", int'(frame_idx), 0);
        q1.delete();
        q2.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_ticks = 0;
        m_prev_en = 0;
        m_os = anim_oneshot;
        for (int i = 0; i < 12; i++) cyc_step(200 + i, 100 + i, i % 2, 0);
        repeat (4) @(negedge clk);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_anim_display.md
Name: sprite_anim_display

Overview:
Parametrised, pipelined sprite renderer for the VGA path. Each pixel, it compares the current scan coordinate against a sprite origin and forms the address for an external synchronous sprite ROM. It then outputs the sprite colour, with colour-key transparency and optional horizontal/vertical mirroring. An internal animation sequencer steps through NUM_FRAMES frames stored back-to-back in the ROM, advancing only on video-frame ticks so the image never changes mid-scan.

Parameters:
SPR_W, 32, sprite width in pixels (power of two)
SPR_H, 32, sprite height in pixels (power of two)
NUM_FRAMES, 4, animation frames stored consecutively in ROM (>=1)
TICKS_PER_FRAME, 8, frame_tick pulses per animation step (>=1)
ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= NUM_FRAMES*SPR_W*SPR_H
COLOR_W, 12, colour width (4:4:4 RGB)
KEY_COLOR, 12'hF0F, ROM colour treated as transparent

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
x  in  11  current pixel column from vga_sync
y  in  10  current pixel row from vga_sync
sprite_x  in  11  sprite top-left column
sprite_y  in  10  sprite top-left row
frame_tick  in  1  one-cycle pulse per video frame (vertical blank)
anim_en  in  1  1 = animation runs, 0 = hold current frame
anim_oneshot  in  1  0 = loop, 1 = play once and stop on last frame
restart  in  1  one-cycle pulse: rewind to frame 0
flip_h  in  1  mirror horizontally
flip_v  in  1  mirror vertically
rom_addr  out  ADDR_W  address to sprite ROM (ROM registers data, 1-cycle read latency)
rom_data  in  COLOR_W  ROM colour for the address presented the previous cycle
rgb_out  out  COLOR_W  pixel colour; 0 when not drawing
pixel_on  out  1  1 = opaque sprite pixel at this output slot
frame_idx  out  clog2(NUM_FRAMES), min 1  current animation frame
anim_done  out  1  one-shot finished, holding last frame

Behaviour:
- Reset (async, rst_n=0): state=IDLE, frame_idx=0, tick counter=0, anim_done=0, rom_addr=0, all pipeline valid bits=0, rgb_out=0, pixel_on=0.
- Hit test, combinational on stage 0:
  - dx = {1'b0,x} - {1'b0,sprite_x} (12 bits); dy = {1'b0,y} - {1'b0,sprite_y} (11 bits).
  - hit = no borrow on either subtraction && dx < SPR_W && dy < SPR_H. No wrap-around hits at the screen edges.
- Addressing:
  - col = flip_h ? SPR_W-1-dx : dx; row = flip_v ? SPR_H-1-dy : dy (low bits).
  - rom_addr = frame_idx*SPR_W*SPR_H + row*SPR_W + col, truncated to ADDR_W. Registered in stage 1.
- Pipeline, fixed latency 2 cycles from x/y to rgb_out/pixel_on:
  - Cycle N: x,y sampled; rom_addr and hit_d1 registered.
  - Cycle N+1: ROM produces rom_data; hit_d1 moves to hit_d2.
  - Cycle N+2: rgb_out = (hit_d2 && rom_data!=KEY_COLOR) ? rom_data : 0; pixel_on equals the same condition, registered.
  - When hit=0, rom_addr still updates (don't care) but the output is forced to 0.
- Animation FSM, states IDLE, PLAY, DONE:
  - IDLE: frame held. Goes to PLAY when anim_en=1.
  - PLAY: each frame_tick increments the tick counter. When tick counter = TICKS_PER_FRAME-1 and frame_tick=1: tick counter goes to 0 and frame advances.
    - Advance at frame_idx=NUM_FRAMES-1 with anim_oneshot=0: wrap to 0.
    - Advance at frame_idx=NUM_FRAMES-1 with anim_oneshot=1: stay on last frame, state=DONE, anim_done=1.
    - anim_en=0 returns to IDLE; tick counter is retained.
  - DONE: frame and anim_done held. Leaves only via restart or reset.
- restart: frame_idx=0, tick counter=0, anim_done=0, next state = anim_en ? PLAY : IDLE.
  - Restart beats a coincident frame_tick.
  - The new frame is visible from the next rom_addr.
- NUM_FRAMES=1: frame_idx stays 0. In one-shot mode the first advance enters DONE.
- Changing flip_h/flip_v/sprite_x/sprite_y mid-line is permitted; the effect follows the 2-cycle latency with no glitch filtering.

Test Plan:
- Reset mid-operation: drive rst_n=0 asynchronously while drawing -> rgb_out=0, pixel_on=0, frame_idx=0 immediately; after release, first valid output 2 cycles after first x/y.
- Hit bounds: sprite_x=100, sprite_y=50; scan x=99..132, y=50 -> pixel_on high exactly for x=100..131, delayed 2 cycles. With sprite_x=2040, x=0..5 -> no hit.
- Addressing/flip: frame 0, x=101, y=52 -> rom_addr=2*32+1=65. flip_h=1 -> 2*32+30=94. flip_v=1, flip_h=0 -> 29*32+1=929.
- Transparency: ROM returns 12'hF0F at a hit pixel -> rgb_out=0, pixel_on=0. ROM returns 12'h0A3 -> rgb_out=12'h0A3, pixel_on=1.
- Loop animation: anim_en=1, 32 frame_ticks -> frame_idx sequence 0,1,2,3 changing every 8 ticks, back to 0 at tick 32. During frame 2, rom_addr for dx=dy=0 is 2048.
- One-shot + restart: anim_oneshot=1, 32 ticks -> frame_idx=3, anim_done=1, further ticks ignored. Restart coincident with frame_tick -> frame_idx=0, anim_done=0, state PLAY.
